// File: rtl/snake_pkg.sv
// snake_pkg: playfield geometry, the segment coordinate pair and the
// snake_body FSM encoding shared by the snake_body files.
package snake_pkg;

   localparam int COORD_W = 7;
   localparam int GRID_W  = 64;
   localparam int GRID_H  = 48;

   // One body segment as stored in the segment buffer.
   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_pair_t;

   localparam logic [2:0] ST_INIT_ENC   = 3'd0;
   localparam logic [2:0] ST_IDLE_ENC   = 3'd1;
   localparam logic [2:0] ST_SCAN_ENC   = 3'd2;
   localparam logic [2:0] ST_COMMIT_ENC = 3'd3;
   localparam logic [2:0] ST_DEAD_ENC   = 3'd4;

   typedef enum logic [2:0] {
      ST_INIT   = ST_INIT_ENC,
      ST_IDLE   = ST_IDLE_ENC,
      ST_SCAN   = ST_SCAN_ENC,
      ST_COMMIT = ST_COMMIT_ENC,
      ST_DEAD   = ST_DEAD_ENC
   } state_e;

endpackage

// File: rtl/snake_seg_ram.sv
// snake_seg_ram: segment buffer with one write port and two asynchronous
// read ports (collision scan / tail fetch, and renderer readout).
module snake_seg_ram
   import snake_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  coord_pair_t   wdata,
   input  logic [AW-1:0] scan_addr,
   output coord_pair_t   scan_data,
   input  logic [AW-1:0] rd_addr,
   output coord_pair_t   rd_data
);

   coord_pair_t mem_r [DEPTH];

   // Single write port; the array has no reset, INIT fills the live part.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign scan_data = mem_r[scan_addr];
   assign rd_data   = mem_r[rd_addr];

endmodule

// File: rtl/snake_body.sv
// snake_body: circular buffer of snake segments with wall / self collision
// check, commit, growth and tail-erase reporting, plus registered readout.
// Optional build macro SNAKE_WRAP_EN: heads one step past a wall wrap to
// the opposite edge instead of killing the snake.
module snake_body
   import snake_pkg::*;
#(
   parameter  int MAX_LEN  = 64,
   parameter  int INIT_LEN = 3,
   parameter  int INIT_X   = 1,
   parameter  int INIT_Y   = 1,
   localparam int AW       = $clog2(MAX_LEN)
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               i_Step,
   input  logic [COORD_W-1:0] i_Head_x,
   input  logic [COORD_W-1:0] i_Head_y,
   input  logic               i_Grow,
   input  logic [AW-1:0]      i_Rd_Idx,
   output logic [COORD_W-1:0] o_Rd_x,
   output logic [COORD_W-1:0] o_Rd_y,
   output logic               o_Rd_Vld,
   output logic [COORD_W-1:0] o_Tail_x,
   output logic [COORD_W-1:0] o_Tail_y,
   output logic               o_Tail_Vld,
   output logic [AW:0]        o_Len,
   output logic               o_Busy,
   output logic               o_Done,
   output logic               o_Dead,
   output logic               o_Full
);

   localparam logic [AW-1:0]      ONE_A       = AW'(1);
   localparam logic [AW:0]        ONE_L       = (AW+1)'(1);
   localparam logic [AW:0]        LEN_MAX_C   = (AW+1)'(MAX_LEN);
   localparam logic [AW:0]        LEN_INIT_C  = (AW+1)'(INIT_LEN);
   localparam logic [AW-1:0]      INIT_LAST_C = AW'(INIT_LEN - 1);
   localparam logic [COORD_W-1:0] INIT_X_C    = COORD_W'(INIT_X);
   localparam logic [COORD_W-1:0] INIT_Y_C    = COORD_W'(INIT_Y);
   localparam logic [COORD_W-1:0] GRID_W_C    = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] GRID_H_C    = COORD_W'(GRID_H);

   // Returns {kill, mapped coordinate} for one axis against its limit.
   function automatic logic [COORD_W:0] fit_coord(input logic [COORD_W-1:0] v,
                                                  input logic [COORD_W-1:0] lim);
      logic [COORD_W:0] r;
`ifdef SNAKE_WRAP_EN
      if (v == {COORD_W{1'b1}}) begin
         r = {1'b0, lim - COORD_W'(1)};
      end else if (v == lim) begin
         r = {1'b0, {COORD_W{1'b0}}};
      end else if (v > lim) begin
         r = {1'b1, v};
      end else begin
         r = {1'b0, v};
      end
`else
      if (v >= lim) begin
         r = {1'b1, v};
      end else begin
         r = {1'b0, v};
      end
`endif
      return r;
   endfunction

   state_e           state_r, state_nxt_s;
   logic [AW-1:0]    hp_r, init_k_r;
   logic [AW:0]      len_r, scan_idx_r, scan_cnt_r, len_inc_s;
   coord_pair_t      head_r;
   logic             grow_r, chk_r;
   logic [COORD_W:0] fit_x_s, fit_y_s;
   logic             wall_s, hit_s, grow_ok_s;
   logic             ram_we_s;
   logic [AW-1:0]    ram_waddr_s, scan_addr_s, rd_addr_s;
   coord_pair_t      ram_wdata_s, scan_data_s, rd_data_s;

   snake_seg_ram #(.DEPTH(MAX_LEN)) u_seg_ram (
      .clk       (Clk),
      .we        (ram_we_s),
      .waddr     (ram_waddr_s),
      .wdata     (ram_wdata_s),
      .scan_addr (scan_addr_s),
      .scan_data (scan_data_s),
      .rd_addr   (rd_addr_s),
      .rd_data   (rd_data_s)
   );

   assign o_Len = len_r;

   // Head classification, body-hit compare and buffer address generation.
   always_comb begin
      fit_x_s   = fit_coord(head_r.x, GRID_W_C);
      fit_y_s   = fit_coord(head_r.y, GRID_H_C);
      wall_s    = fit_x_s[COORD_W] | fit_y_s[COORD_W];
      hit_s     = (scan_data_s == head_r);
      grow_ok_s = i_Grow & (len_r < LEN_MAX_C);
      len_inc_s = len_r + ONE_L;
      rd_addr_s = hp_r - i_Rd_Idx;
      if (state_r == ST_COMMIT) begin
         scan_addr_s = hp_r - len_r[AW-1:0] + ONE_A;   // oldest segment
      end else begin
         scan_addr_s = hp_r - scan_idx_r[AW-1:0];
      end
   end

   // Next-state logic and segment buffer write control.
   always_comb begin
      state_nxt_s = state_r;
      ram_we_s    = 1'b0;
      ram_waddr_s = hp_r + ONE_A;
      ram_wdata_s = head_r;
      case (state_r)
         ST_INIT: begin
            ram_we_s      = 1'b1;
            ram_waddr_s   = init_k_r;
            ram_wdata_s.x = INIT_X_C + COORD_W'(init_k_r);
            ram_wdata_s.y = INIT_Y_C;
            if (init_k_r == INIT_LAST_C) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_IDLE: begin
            if (i_Step) begin
               state_nxt_s = ST_SCAN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (chk_r) begin
               // first SCAN cycle only classifies the latched head
               if (wall_s) begin
                  state_nxt_s = ST_DEAD;
               end else begin
                  state_nxt_s = ST_SCAN;
               end
            end else if (hit_s) begin
               state_nxt_s = ST_DEAD;
            end else if (scan_idx_r == scan_cnt_r - ONE_L) begin
               state_nxt_s = ST_COMMIT;
            end else begin
               state_nxt_s = ST_SCAN;
            end
         end
         ST_COMMIT: begin
            ram_we_s    = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         ST_DEAD: begin
            state_nxt_s = ST_DEAD;
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= ST_INIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Pointers, latched step, scan counters and all registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         hp_r       <= '0;
         init_k_r   <= '0;
         len_r      <= '0;
         scan_idx_r <= '0;
         scan_cnt_r <= '0;
         head_r     <= '0;
         grow_r     <= 1'b0;
         chk_r      <= 1'b0;
         o_Rd_x     <= '0;
         o_Rd_y     <= '0;
         o_Rd_Vld   <= 1'b0;
         o_Tail_x   <= '0;
         o_Tail_y   <= '0;
         o_Tail_Vld <= 1'b0;
         o_Busy     <= 1'b1;
         o_Done     <= 1'b0;
         o_Dead     <= 1'b0;
         o_Full     <= 1'b0;
      end else begin
         o_Done     <= 1'b0;
         o_Tail_Vld <= 1'b0;
         o_Busy     <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_SCAN) ||
                       (state_nxt_s == ST_COMMIT);
         o_Rd_x     <= rd_data_s.x;
         o_Rd_y     <= rd_data_s.y;
         o_Rd_Vld   <= ({1'b0, i_Rd_Idx} < len_r);
         case (state_r)
            ST_INIT: begin
               hp_r     <= init_k_r;
               init_k_r <= init_k_r + ONE_A;
               if (init_k_r == INIT_LAST_C) begin
                  len_r  <= LEN_INIT_C;
                  o_Full <= (LEN_INIT_C == LEN_MAX_C);
               end
            end
            ST_IDLE: begin
               if (i_Step) begin
                  head_r.x   <= i_Head_x;
                  head_r.y   <= i_Head_y;
                  grow_r     <= grow_ok_s;   // growth at full length saturates
                  chk_r      <= 1'b1;
                  scan_idx_r <= '0;
                  scan_cnt_r <= grow_ok_s ? len_r : (len_r - ONE_L);
               end
            end
            ST_SCAN: begin
               if (chk_r) begin
                  chk_r    <= 1'b0;
                  head_r.x <= fit_x_s[COORD_W-1:0];
                  head_r.y <= fit_y_s[COORD_W-1:0];
                  if (wall_s) begin
                     o_Dead <= 1'b1;
                     o_Done <= 1'b1;
                  end
               end else begin
                  scan_idx_r <= scan_idx_r + ONE_L;
                  if (hit_s) begin
                     o_Dead <= 1'b1;
                     o_Done <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               hp_r   <= hp_r + ONE_A;
               o_Done <= 1'b1;
               if (grow_r) begin
                  len_r  <= len_inc_s;
                  o_Full <= (len_inc_s == LEN_MAX_C);
               end else begin
                  o_Tail_x   <= scan_data_s.x;
                  o_Tail_y   <= scan_data_s.y;
                  o_Tail_Vld <= 1'b1;
               end
            end
            ST_DEAD: begin
               hp_r <= hp_r;
            end
            default: begin
               hp_r <= hp_r;
            end
         endcase
      end
   end

endmodule
